frodo_host_bridge: RTL
======================

Name: frodo_host_bridge

Overview:
- Host-facing load/unload stage that sits directly upstream and downstream of the Frodo core datapath.
- Streams 64-bit host words (seeds, pk/ct words, µ) into RAM64 port A0 at a configured base address, then pulses the core start.
- Waits for core work_done, then reads a configured result window back out of RAM64 port A0 as a 64-bit stream with backpressure.
- Owns RAM port A0 only while busy; the core owns it otherwise.

Parameters:
ADDR_W, 12, RAM64 word-address width
DATA_W, 64, word width
LEN_W, 13, transfer length width in words (0..4096)

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
go  in  1  single-cycle command; sampled only in IDLE
load_base  in  ADDR_W  first RAM address written by the load phase
load_len  in  LEN_W  number of words to load; 0 skips the load phase
unload_base  in  ADDR_W  first RAM address read by the unload phase
unload_len  in  LEN_W  number of words to unload; 0 skips the unload phase
in_data  in  DATA_W  host input word
in_valid  in  1  host input word valid
in_ready  out  1  bridge accepts in_data
out_data  out  DATA_W  result word
out_valid  out  1  result word valid
out_ready  in  1  host accepts out_data
out_last  out  1  marks the final unload word
ram_we  out  1  RAM64 A0 write enable
ram_addr  out  ADDR_W  RAM64 A0 address
ram_din  out  DATA_W  RAM64 A0 write data
ram_dout  in  DATA_W  RAM64 A0 read data, 1-cycle latency after ram_addr
core_start  out  1  one-cycle start pulse to the control FSM
core_done  in  1  work_done from the core, level or pulse
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when UNLOAD completes

Behaviour:
- Reset: all outputs are 0, ram_addr is 0, FSM is IDLE, counters are 0, skid buffer is empty.
- Reset asserted mid-operation aborts immediately to IDLE; a partially loaded RAM is left as is.
- go in IDLE latches base and len for both phases; go is ignored while busy.
- Next state after go: LOAD if load_len != 0, otherwise START.
- LOAD:
  - in_ready = 1.
  - On in_valid&&in_ready: ram_we = 1, ram_addr = load_base + cnt, ram_din = in_data, cnt++.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - After load_len beats, go to START; in_ready drops in the same cycle the last beat is accepted.
- START: core_start = 1 for exactly one cycle, then WAIT.
- WAIT:
  - Waits for core_done == 1.
  - A core_done already high in the START cycle is captured into a sticky flag and honoured the next cycle.
  - Next state is UNLOAD, or DONE if unload_len == 0.
- UNLOAD:
  - Issues a read (ram_addr = unload_base + rd_cnt) when rd_cnt < unload_len and occupancy + inflight < 2.
  - ram_dout is captured into a 2-entry skid FIFO one cycle after issue.
  - The FIFO head drives out_data/out_valid.
  - out_data and out_valid are held stable while out_valid && !out_ready.
  - Throughput is 1 word/cycle when out_ready is held high; first word latency is 2 cycles after UNLOAD entry.
  - out_last = 1 on the word whose index is unload_len-1.
  - After the last handshake, go to DONE.
- DONE: done = 1 for one cycle, then IDLE (busy drops).
- ram_we is 0 outside LOAD beats, and ram_din is 0 when ram_we is 0.
- Simultaneous go and core_done in IDLE: go wins; a core_done seen in IDLE is discarded.

Test Plan:
- Load only: go, load_base=0x100, load_len=3, unload_len=0, words A,B,C with in_valid held high -> RAM writes 0x100/0x101/0x102 on 3 consecutive cycles; core_start 1 cycle later; core_done -> done pulse; busy low next cycle.
- Unload with stalls: RAM[0x200..0x203] = 1,2,3,4, load_len=0, unload_len=4, out_ready toggling 1,0,1,0 -> out sequence 1,2,3,4 with no drop or duplicate; out_last only on 4.
- Full rate: unload_len=16, out_ready held high -> 16 words on consecutive cycles after the 2-cycle latency.
- Wrap: load_base=0xFFE, load_len=4 -> writes go to 0xFFE, 0xFFF, 0x000, 0x001.
- Early done: core_done high in the START cycle -> WAIT exits on the next cycle; no hang.
- Reset mid-UNLOAD after 2 of 5 words -> all outputs 0 in the same cycle as reset; busy=0; a new go works normally.

Source files
------------

// File: rtl/frodo_host_bridge.sv
// Host load/unload bridge for the Frodo core: streams host words into RAM64 port A0,
// kicks the core, then streams a result window back out with backpressure.
module frodo_host_bridge #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [LEN_W-1:0]  load_len,
    input  logic [ADDR_W-1:0] unload_base,
    input  logic [LEN_W-1:0]  unload_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              core_start,
    input  logic              core_done,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UNLOAD = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]              state, state_n;
    logic [ADDR_W-1:0]       load_base_q, unload_base_q;
    logic [LEN_W-1:0]        load_len_q, unload_len_q;
    logic [LEN_W-1:0]        cnt, rd_cnt, out_cnt;
    logic                    done_flag;
    logic                    inflight;
    logic [1:0][DATA_W-1:0]  fifo;
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              occ;

    logic                    beat, pop, issue, last_beat, last_word;
    logic [1:0]              fill;

    assign in_ready   = (state == S_LOAD);
    assign beat       = in_ready && in_valid;
    assign last_beat  = beat && (cnt == load_len_q - LEN_W'(1));
    assign ram_we     = beat;
    assign ram_din    = beat ? in_data : '0;

    assign out_valid  = (occ != 2'd0);
    assign out_data   = out_valid ? fifo[rd_ptr] : '0;
    assign last_word  = (out_cnt == unload_len_q - LEN_W'(1));
    assign out_last   = out_valid && last_word;
    assign pop        = out_valid && out_ready;

    // Room check counts the word leaving this cycle so a held-high out_ready sustains 1 word/cycle.
    assign fill       = occ + {1'b0, inflight} - {1'b0, pop};
    assign issue      = (state == S_UNLOAD) && (rd_cnt < unload_len_q) && (fill < 2'd2);

    always_comb begin
        ram_addr = '0;
        if (beat)
            ram_addr = load_base_q + ADDR_W'(cnt);
        else if (issue)
            ram_addr = unload_base_q + ADDR_W'(rd_cnt);
    end

    assign core_start = (state == S_START);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (go) state_n = (load_len != '0) ? S_LOAD : S_START;
            S_LOAD:   if (last_beat) state_n = S_START;
            S_START:  state_n = S_WAIT;
            S_WAIT:   if (core_done || done_flag)
                          state_n = (unload_len_q != '0) ? S_UNLOAD : S_DONE;
            S_UNLOAD: if (pop && last_word) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            load_base_q   <= '0;
            load_len_q    <= '0;
            unload_base_q <= '0;
            unload_len_q  <= '0;
            cnt           <= '0;
            rd_cnt        <= '0;
            out_cnt       <= '0;
            done_flag     <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && go) begin
                load_base_q   <= load_base;
                load_len_q    <= load_len;
                unload_base_q <= unload_base;
                unload_len_q  <= unload_len;
                cnt           <= '0;
                rd_cnt        <= '0;
                out_cnt       <= '0;
            end else begin
                if (beat)  cnt     <= cnt + LEN_W'(1);
                if (issue) rd_cnt  <= rd_cnt + LEN_W'(1);
                if (pop)   out_cnt <= out_cnt + LEN_W'(1);
            end
            // A done that arrives while start is still high must not be lost; IDLE-time dones are dropped.
            if (state == S_START)
                done_flag <= core_done;
            else if (state != S_WAIT)
                done_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight <= 1'b0;
            fifo     <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            occ      <= 2'd0;
        end else begin
            inflight <= issue;
            if (inflight) begin
                fifo[wr_ptr] <= ram_dout;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule
